addsub_pipe: RTL and testbench
==============================

# addsub_pipe

Parametrised, segment-pipelined integer add/subtract unit with carry-in modes, ALU condition flags and valid/ready flow control. It replaces the single-cycle 32-bit subtractor in the datapath. The carry chain is split into SEG-bit segments, with one segment resolved per stage, so clock period is bounded by a SEG-bit ripple. Full throughput is one operation per cycle. It sits between operand select and the result/flag write-back in the execute stage.

## Interface
- WIDTH, 32, operand/result width; must be a multiple of SEG
- SEG, 8, segment width resolved per stage; STAGES = WIDTH/SEG (1 allowed)
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operand beat offered
- in_ready  out  1  unit can accept a beat this cycle
- op  in  2  00 ADD (A+B), 01 SUB (A+~B+1), 10 ADC (A+B+cin), 11 SBB (A+~B+cin)
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in; used by ADC/SBB only (for SBB, 1 = no borrow)
- out_valid  out  1  result beat available
- out_ready  in  1  consumer accepts result
- result  out  WIDTH  sum/difference, modulo 2^WIDTH
- c_flag  out  1  raw carry out of MSB (for SUB/SBB: 1 = no borrow)
- v_flag  out  1  signed overflow = carry into MSB XOR carry out of MSB
- n_flag  out  1  result[WIDTH-1]
- z_flag  out  1  result == 0

## Operation
- Operand transform at entry: b_eff = ~b for SUB/SBB, else b. c0 = 1 for SUB, 0 for ADD, cin for ADC/SBB.
- Stage k (0..STAGES-1) adds segment k of a and b_eff plus the carry registered from stage k-1 (c0 for k=0).
  - It registers the SEG-bit sum, the carry out, and a running zero bit (AND of segment-zero terms so far).
  - Unprocessed upper segments of a/b_eff travel with the beat. Completed lower result segments travel with it too.
- The last stage also registers carry-into-MSB for v_flag. Flags are generated in the final stage register, not combinationally after it.
- Each stage holds a valid bit. Bubbles (invalid stages) propagate and do not block.
- Global advance = !out_valid || out_ready. On advance every stage shifts one step; otherwise all stages hold.
- in_ready = advance. A beat transfers when in_valid && in_ready.
- Outputs come straight from the final stage register. result and flags are stable while out_valid && !out_ready.
- Arithmetic is unsigned modulo 2^WIDTH. Signed interpretation is reflected only via v_flag and n_flag.

## Timing
- Latency: a beat transferred at edge n presents out_valid=1 immediately after edge n+STAGES-1, assuming no stall. STAGES=1 gives a single registered adder.
- Throughput: one beat per cycle while out_ready=1.
- Backpressure: with out_valid=1 and out_ready=0, in_ready=0 in the same cycle (combinational from out_valid/out_ready). No beat is lost or duplicated.
- Simultaneous out-handshake and in-handshake in one cycle is legal. The pipeline shifts, the old result retires, and the new beat enters.
- Reset (reset_n=0, any time, asynchronous): all stage valids = 0, out_valid=0, result=0, c/v/n flags=0, z_flag=0.
  - in_ready = 1 once reset_n is high.
  - Beats in flight at reset are discarded. No output is produced for them after release.
- Inputs a/b/op/cin are sampled only on a transfer edge. Their values when in_valid=0 are don't-care.

## Test plan
- WIDTH=32, SEG=8, out_ready=1: SUB 5-3 -> result 0x00000002, C=1 V=0 N=0 Z=0, out_valid exactly 4 cycles after transfer (3 edges after). SUB 3-5 -> 0xFFFFFFFE, C=0 N=1 V=0 Z=0.
- ADD 0x7FFFFFFF+0x00000001 -> 0x80000000, V=1 N=1 C=0 Z=0. ADD 0xFFFFFFFF+0x00000001 -> 0x00000000, C=1 Z=1 V=0. This exercises carry ripple across all four segments.
- ADC 0x000000FF+0x00000000, cin=1 -> 0x00000100 C=0. SBB 10-3 with cin=0 -> 6, C=1. SBB 0-0 with cin=0 -> 0xFFFFFFFF, C=0 N=1.
- Back-to-back: 8 random beats on consecutive cycles with out_ready=1. Then hold out_ready=0 for 5 cycles mid-stream.
  - Expect in_ready=0 during the stall and the held output stable.
  - All 8 results arrive in order, match a reference model, and none are dropped or duplicated.
- Reset mid-operation: assert reset_n=0 with 3 beats in flight. Expect out_valid=0 and all outputs 0 immediately, and no stale beat after release. A fresh SUB 1-1 then gives 0, Z=1 C=1.
- Parameter sweep: SEG=32 (STAGES=1, latency 1) and WIDTH=16/SEG=4, each with 1000 random beats against a reference model including all four flags.

Source files
------------

// File: rtl/addsub_pipe_if.sv
// Operand/result handshake bundle for addsub_pipe.
// The master side offers operands and consumes results; the slave side is the adder.
interface addsub_pipe_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             c_flag;
  logic             v_flag;
  logic             n_flag;
  logic             z_flag;

  modport master (
    output in_valid, op, a, b, cin, out_ready,
    input  in_ready, out_valid, result, c_flag, v_flag, n_flag, z_flag
  );

  modport slave (
    input  in_valid, op, a, b, cin, out_ready,
    output in_ready, out_valid, result, c_flag, v_flag, n_flag, z_flag
  );
endinterface

// File: rtl/addsub_pipe.sv
// Segment-pipelined add/subtract with carry-in modes and C/V/N/Z flags.
// One SEG-bit slice of the carry chain is resolved per stage; all stages advance together.
module addsub_pipe #(
  parameter int WIDTH = 32,
  parameter int SEG   = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  addsub_pipe_if.slave bus
);

  localparam int STAGES = WIDTH / SEG;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;

  // SUB and SBB both use the inverted B operand.
  function automatic logic [WIDTH-1:0] b_transform(input logic [1:0] op,
                                                   input logic [WIDTH-1:0] b);
    return op[0] ? ~b : b;
  endfunction

  function automatic logic carry_seed(input logic [1:0] op, input logic cin);
    logic c0;
    case (op)
      OP_ADD:  c0 = 1'b0;
      OP_SUB:  c0 = 1'b1;
      default: c0 = cin;
    endcase
    return c0;
  endfunction

  logic advance;

  assign advance      = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = advance;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int IN_W = WIDTH - k * SEG;

    logic                   vld_in;
    logic [IN_W-1:0]        a_in;
    logic [IN_W-1:0]        b_in;
    logic                   c_in;
    logic                   z_in;
    logic [SEG:0]           seg_sum;
    logic [(k+1)*SEG-1:0]   r_nxt;
    logic                   z_nxt;
    logic                   vld_p;

    if (k == 0) begin : g_first
      assign vld_in = bus.in_valid;
      assign a_in   = bus.a;
      assign b_in   = b_transform(bus.op, bus.b);
      assign c_in   = carry_seed(bus.op, bus.cin);
      assign z_in   = 1'b1;
      assign r_nxt  = seg_sum[SEG-1:0];
    end else begin : g_next
      assign vld_in = g_stage[k-1].vld_p;
      assign a_in   = g_stage[k-1].g_mid.a_p;
      assign b_in   = g_stage[k-1].g_mid.b_p;
      assign c_in   = g_stage[k-1].g_mid.c_p;
      assign z_in   = g_stage[k-1].g_mid.z_p;
      assign r_nxt  = {seg_sum[SEG-1:0], g_stage[k-1].g_mid.r_p};
    end

    assign seg_sum = {1'b0, a_in[SEG-1:0]} + {1'b0, b_in[SEG-1:0]} + {{SEG{1'b0}}, c_in};
    assign z_nxt   = z_in && (seg_sum[SEG-1:0] == '0);

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        vld_p <= 1'b0;
      end else if (advance) begin
        vld_p <= vld_in;
      end
    end

    if (k < STAGES - 1) begin : g_mid
      // ---- stage boundary: carry, done segments and untouched upper operand bits ----
      logic [IN_W-SEG-1:0]  a_p;
      logic [IN_W-SEG-1:0]  b_p;
      logic [(k+1)*SEG-1:0] r_p;
      logic                 c_p;
      logic                 z_p;

      always_ff @(posedge clk) begin
        if (advance) begin
          a_p <= a_in[IN_W-1:SEG];
          b_p <= b_in[IN_W-1:SEG];
          r_p <= r_nxt;
          c_p <= seg_sum[SEG];
          z_p <= z_nxt;
        end
      end
    end else begin : g_last
      // ---- final stage boundary: result and flags drive the outputs directly ----
      logic [WIDTH-1:0] result_p;
      logic             c_p;
      logic             v_p;
      logic             n_p;
      logic             z_p;
      logic             c_msb;

      // sum_msb = a ^ b ^ carry_in, so the carry into the MSB falls out of the sum bit.
      assign c_msb = a_in[SEG-1] ^ b_in[SEG-1] ^ seg_sum[SEG-1];

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          result_p <= '0;
          c_p      <= 1'b0;
          v_p      <= 1'b0;
          n_p      <= 1'b0;
          z_p      <= 1'b0;
        end else if (advance) begin
          result_p <= r_nxt;
          c_p      <= seg_sum[SEG];
          v_p      <= c_msb ^ seg_sum[SEG];
          n_p      <= seg_sum[SEG-1];
          z_p      <= z_nxt;
        end
      end
    end
  end

  assign bus.out_valid = g_stage[STAGES-1].vld_p;
  assign bus.result    = g_stage[STAGES-1].g_last.result_p;
  assign bus.c_flag    = g_stage[STAGES-1].g_last.c_p;
  assign bus.v_flag    = g_stage[STAGES-1].g_last.v_p;
  assign bus.n_flag    = g_stage[STAGES-1].g_last.n_p;
  assign bus.z_flag    = g_stage[STAGES-1].g_last.z_p;

endmodule

// File: tb/tb_addsub_pipe.sv
// Scoreboard bench for addsub_pipe: 32/8 main instance plus 32/32 and 16/4 sweep instances.
module tb_addsub_pipe;

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  addsub_pipe_if #(.WIDTH(32)) ifm ();
  addsub_pipe_if #(.WIDTH(32)) ifs ();
  addsub_pipe_if #(.WIDTH(16)) ifw ();

  addsub_pipe #(.WIDTH(32), .SEG(8))  u_main (.clk(clk), .reset_n(reset_n), .bus(ifm.slave));
  addsub_pipe #(.WIDTH(32), .SEG(32)) u_one  (.clk(clk), .reset_n(reset_n), .bus(ifs.slave));
  addsub_pipe #(.WIDTH(16), .SEG(4))  u_nar  (.clk(clk), .reset_n(reset_n), .bus(ifw.slave));

  logic [35:0] obs_m, obs_s, obs_w;
  assign obs_m = {ifm.c_flag, ifm.v_flag, ifm.n_flag, ifm.z_flag, ifm.result};
  assign obs_s = {ifs.c_flag, ifs.v_flag, ifs.n_flag, ifs.z_flag, ifs.result};
  assign obs_w = {ifw.c_flag, ifw.v_flag, ifw.n_flag, ifw.z_flag, 16'd0, ifw.result};

  // Reference: {C, V, N, Z, result} for a w-bit unit, zero-extended to 32 bits.
  function automatic logic [35:0] ref_calc(input int w, input logic [1:0] op,
                                           input logic [31:0] a, input logic [31:0] b,
                                           input logic cin);
    logic [63:0] mask, aa, bb, full;
    logic [31:0] r;
    logic        c0, c, v, n, z;
    mask = (64'd1 << w) - 64'd1;
    aa   = {32'd0, a} & mask;
    bb   = (op[0] ? ~{32'd0, b} : {32'd0, b}) & mask;
    c0   = (op == 2'b01) ? 1'b1 : (op == 2'b00) ? 1'b0 : cin;
    full = aa + bb + {63'd0, c0};
    r    = full[31:0] & mask[31:0];
    c    = full[w];
    n    = r[w-1];
    v    = (aa[w-1] == bb[w-1]) && (n != aa[w-1]);
    z    = (r == 32'd0);
    return {c, v, n, z, r};
  endfunction

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (ifm.out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid: got %b expected 0", ifm.out_valid);
    end
    checks++;
    if (obs_m !== 36'd0) begin
      errors++; $display("FAIL reset_result_flags: got %h expected 0", obs_m);
    end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    checks++;
    if (ifm.in_ready !== 1'b1 || ifs.in_ready !== 1'b1 || ifw.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b%b%b expected 111", ifm.in_ready, ifs.in_ready, ifw.in_ready);
    end
  endtask

  task automatic test_directed();
    logic [1:0]  t_op  [9] = '{2'd1, 2'd1, 2'd0, 2'd0, 2'd2, 2'd3, 2'd3, 2'd1, 2'd0};
    logic [31:0] t_a   [9] = '{32'd5, 32'd3, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFF, 32'd10, 32'd0,
                               32'h80000000, 32'd1};
    logic [31:0] t_b   [9] = '{32'd3, 32'd5, 32'd1, 32'd1, 32'd0, 32'd3, 32'd0, 32'd1, 32'd1};
    logic        t_cin [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [31:0] t_res [9] = '{32'd2, 32'hFFFFFFFE, 32'h80000000, 32'd0, 32'h100, 32'd6,
                               32'hFFFFFFFF, 32'h7FFFFFFF, 32'd2};
    logic [3:0]  t_flg [9] = '{4'b1000, 4'b0010, 4'b0110, 4'b1001, 4'b0000, 4'b1000, 4'b0010,
                               4'b1100, 4'b0000};
    int lat;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      ifm.op = t_op[i]; ifm.a = t_a[i]; ifm.b = t_b[i]; ifm.cin = t_cin[i];
      ifm.out_ready = 1'b1;
      ifm.in_valid  = 1'b1;
      @(negedge clk);
      ifm.in_valid = 1'b0;
      lat = 1;
      while (ifm.out_valid !== 1'b1 && lat < 20) begin
        @(negedge clk);
        lat++;
      end
      checks++;
      if (lat != 4) begin
        errors++; $display("FAIL dir%0d_latency: got %0d expected 4", i, lat);
      end
      checks++;
      if (obs_m !== {t_flg[i], t_res[i]}) begin
        errors++; $display("FAIL dir%0d_value: got %h expected %h", i, obs_m, {t_flg[i], t_res[i]});
      end
      @(negedge clk);
      checks++;
      if (ifm.out_valid !== 1'b0) begin
        errors++; $display("FAIL dir%0d_no_dup: got %b expected 0", i, ifm.out_valid);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [35:0] q[$];
    logic [35:0] held = '0;
    logic [35:0] e;
    logic        hold_prev = 1'b0;
    int sent = 0, got = 0, cyc = 0;
    while (got < 8 && cyc < 200) begin
      @(negedge clk);
      if (hold_prev) begin
        checks++;
        if (obs_m !== held) begin
          errors++; $display("FAIL b2b_hold: got %h expected %h", obs_m, held);
        end
      end
      ifm.out_ready = !(cyc >= 6 && cyc < 11);
      ifm.in_valid  = (sent < 8);
      ifm.op  = 2'($urandom_range(0, 3));
      ifm.a   = $urandom();
      ifm.b   = $urandom();
      ifm.cin = 1'($urandom_range(0, 1));
      #1;
      if (ifm.out_valid && !ifm.out_ready) begin
        checks++;
        if (ifm.in_ready !== 1'b0) begin
          errors++; $display("FAIL b2b_stall_in_ready: got %b expected 0", ifm.in_ready);
        end
      end
      if (ifm.out_valid && ifm.out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL b2b_extra_beat: got %h expected none", obs_m);
        end else begin
          e = q.pop_front();
          if (obs_m !== e) begin
            errors++; $display("FAIL b2b_value%0d: got %h expected %h", got, obs_m, e);
          end
        end
        got++;
      end
      if (ifm.in_valid && ifm.in_ready) begin
        q.push_back(ref_calc(32, ifm.op, ifm.a, ifm.b, ifm.cin));
        sent++;
      end
      hold_prev = ifm.out_valid && !ifm.out_ready;
      held      = obs_m;
      cyc++;
    end
    ifm.in_valid  = 1'b0;
    ifm.out_ready = 1'b1;
    checks++;
    if (got != 8 || q.size() != 0) begin
      errors++; $display("FAIL b2b_count: got %0d beats (%0d pending) expected 8 (0)", got, q.size());
    end
    repeat (6) begin
      @(negedge clk);
      checks++;
      if (ifm.out_valid !== 1'b0) begin
        errors++; $display("FAIL b2b_trailing: got out_valid %b expected 0", ifm.out_valid);
      end
    end
  endtask

  task automatic test_reset_midflight();
    int lat;
    int stale = 0;
    ifm.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ifm.op = 2'b00; ifm.a = 32'(i + 1); ifm.b = 32'h100; ifm.cin = 1'b0;
      ifm.in_valid = 1'b1;
    end
    @(negedge clk);
    ifm.in_valid = 1'b0;
    #1;
    checks++;
    if (obs_m !== {4'b0000, 32'h101} || ifm.out_valid !== 1'b1) begin
      errors++; $display("FAIL mid_prefill: got %b/%h expected 1/%h", ifm.out_valid, obs_m, {4'b0000, 32'h101});
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (ifm.out_valid !== 1'b0 || obs_m !== 36'd0) begin
      errors++; $display("FAIL mid_reset_outputs: got %b/%h expected 0/0", ifm.out_valid, obs_m);
    end
    checks++;
    if (ifm.in_ready !== 1'b1) begin
      errors++; $display("FAIL mid_reset_in_ready: got %b expected 1", ifm.in_ready);
    end
    @(negedge clk);
    reset_n = 1'b1;
    ifm.out_ready = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (ifm.out_valid !== 1'b0) stale++;
    end
    checks++;
    if (stale != 0) begin
      errors++; $display("FAIL mid_stale_beats: got %0d expected 0", stale);
    end
    ifm.op = 2'b01; ifm.a = 32'd1; ifm.b = 32'd1; ifm.cin = 1'b0;
    ifm.in_valid = 1'b1;
    @(negedge clk);
    ifm.in_valid = 1'b0;
    lat = 1;
    while (ifm.out_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat != 4 || obs_m !== {4'b1001, 32'd0}) begin
      errors++; $display("FAIL mid_fresh_sub: got lat %0d val %h expected lat 4 val %h", lat, obs_m, {4'b1001, 32'd0});
    end
  endtask

  task automatic test_sweep_seg32();
    logic [35:0] q[$];
    logic [35:0] e;
    int sent = 0, got = 0, cyc = 0, lat;
    @(negedge clk);
    ifs.op = 2'b01; ifs.a = 32'd7; ifs.b = 32'd9; ifs.cin = 1'b0; ifs.out_ready = 1'b1;
    ifs.in_valid = 1'b1;
    @(negedge clk);
    ifs.in_valid = 1'b0;
    lat = 1;
    while (ifs.out_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat != 1 || obs_s !== {4'b0010, 32'hFFFFFFFE}) begin
      errors++; $display("FAIL s32_latency: got lat %0d val %h expected lat 1 val %h", lat, obs_s, {4'b0010, 32'hFFFFFFFE});
    end
    while (got < 1000 && cyc < 20000) begin
      @(negedge clk);
      ifs.out_ready = ($urandom_range(0, 3) != 0);
      ifs.in_valid  = (sent < 1000) && ($urandom_range(0, 4) != 0);
      ifs.op  = 2'($urandom_range(0, 3));
      ifs.a   = $urandom();
      ifs.b   = ($urandom_range(0, 7) == 0) ? ~ifs.a : $urandom();
      ifs.cin = 1'($urandom_range(0, 1));
      #1;
      if (ifs.out_valid && ifs.out_ready) begin
        checks++;
        e = (q.size() != 0) ? q.pop_front() : 36'hX_XXXX_XXXX;
        if (obs_s !== e) begin
          errors++; $display("FAIL s32_value%0d: got %h expected %h", got, obs_s, e);
        end
        got++;
      end
      if (ifs.in_valid && ifs.in_ready) begin
        q.push_back(ref_calc(32, ifs.op, ifs.a, ifs.b, ifs.cin));
        sent++;
      end
      cyc++;
    end
    ifs.in_valid = 1'b0;
    checks++;
    if (got != 1000 || q.size() != 0) begin
      errors++; $display("FAIL s32_count: got %0d beats (%0d pending) expected 1000 (0)", got, q.size());
    end
  endtask

  task automatic test_sweep_w16();
    logic [35:0] q[$];
    logic [35:0] e;
    int sent = 0, got = 0, cyc = 0;
    while (got < 1000 && cyc < 20000) begin
      @(negedge clk);
      ifw.out_ready = ($urandom_range(0, 3) != 0);
      ifw.in_valid  = (sent < 1000) && ($urandom_range(0, 4) != 0);
      ifw.op  = 2'($urandom_range(0, 3));
      ifw.a   = 16'($urandom());
      ifw.b   = ($urandom_range(0, 7) == 0) ? ifw.a : 16'($urandom());
      ifw.cin = 1'($urandom_range(0, 1));
      #1;
      if (ifw.out_valid && !ifw.out_ready) begin
        checks++;
        if (ifw.in_ready !== 1'b0) begin
          errors++; $display("FAIL w16_stall_in_ready: got %b expected 0", ifw.in_ready);
        end
      end
      if (ifw.out_valid && ifw.out_ready) begin
        checks++;
        e = (q.size() != 0) ? q.pop_front() : 36'hX_XXXX_XXXX;
        if (obs_w !== e) begin
          errors++; $display("FAIL w16_value%0d: got %h expected %h", got, obs_w, e);
        end
        got++;
      end
      if (ifw.in_valid && ifw.in_ready) begin
        q.push_back(ref_calc(16, ifw.op, {16'd0, ifw.a}, {16'd0, ifw.b}, ifw.cin));
        sent++;
      end
      cyc++;
    end
    ifw.in_valid = 1'b0;
    checks++;
    if (got != 1000 || q.size() != 0) begin
      errors++; $display("FAIL w16_count: got %0d beats (%0d pending) expected 1000 (0)", got, q.size());
    end
  endtask

  initial begin
    reset_n = 1'b0;
    ifm.in_valid = 1'b0; ifm.out_ready = 1'b1; ifm.op = '0; ifm.a = '0; ifm.b = '0; ifm.cin = 1'b0;
    ifs.in_valid = 1'b0; ifs.out_ready = 1'b1; ifs.op = '0; ifs.a = '0; ifs.b = '0; ifs.cin = 1'b0;
    ifw.in_valid = 1'b0; ifw.out_ready = 1'b1; ifw.op = '0; ifw.a = '0; ifw.b = '0; ifw.cin = 1'b0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_midflight();
    test_sweep_seg32();
    test_sweep_w16();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached with %0d checks done", checks);
    $fatal(1, "watchdog");
  end

endmodule
